vram_port_arbiter: RTL and testbench
====================================

// Module: vram_port_arbiter
// PURPOSE
//  Shares the single-port VRAM block RAM among three requesters: display refresh reads (from the
//  ILI9341 display controller), paint writes (from the touch/etch-a-sketch drawing logic) and a
//  built-in clear-screen sweep. Arbitrates one RAM access per clock, with fixed priority plus a
//  starvation guard for writes, and sequences full-frame clears on request.
// PARAMETERS
//  DISPLAY_WIDTH  240       pixels per row
//  DISPLAY_HEIGHT 320       rows
//  VRAM_L         W*H       VRAM depth (words); AW = $clog2(VRAM_L)
//  CLEAR_COLOR    16'h0000  ILI9341_color_t written by clear sweep (BLACK)
//  MAX_WR_WAIT    8         cycles a pending write may be blocked by reads before it wins
// PORTS
//  clk          in   1   system clock
//  rstb         in   1   synchronous reset, active low
//  rd_req       in   1   display read request
//  rd_addr      in   AW  display read address
//  rd_ready     out  1   read granted this cycle (comb.)
//  rd_valid     out  1   rd_data valid (1 cycle after grant)
//  rd_data      out  16  read data, ILI9341_color_t
//  wr_req       in   1   paint write request (valid)
//  wr_addr      in   AW  paint write address
//  wr_data      in   16  paint write color
//  wr_ready     out  1   write accepted this cycle (comb.)
//  clear_start  in   1   pulse: begin full-frame clear
//  clear_busy   out  1   clear sweep in progress
//  clear_done   out  1   one-cycle pulse after last clear write
//  ram_addr     out  AW  block RAM address
//  ram_wr_ena   out  1   block RAM write enable
//  ram_wr_data  out  16  block RAM write data
//  ram_rd_data  in   16  block RAM read data (1-cycle latency)
// BEHAVIOUR
//  - Reset (rstb=0 at posedge): state=S_IDLE, clear_addr=0, wait_cnt=0, rd_valid=0, clear_busy=0,
//    clear_done=0. Comb. outputs with no requests: rd_ready=0, wr_ready=0, ram_wr_ena=0, ram_addr=0.
//  - Handshakes: transfer occurs when req & ready in same cycle; requester holds req/addr/data
//    stable until ready. rd_valid asserted exactly 1 cycle after read grant; rd_data=ram_rd_data.
//  - FSM S_IDLE: priority read > write, except when wait_cnt==MAX_WR_WAIT -> write wins, read
//    stalled (rd_ready=0). wait_cnt increments each cycle wr_req is blocked, clears on write grant
//    or when wr_req low; saturates at MAX_WR_WAIT.
//  - S_IDLE -> S_CLEAR on clear_start (same-cycle requests still arbitrated in S_IDLE rules).
//  - S_CLEAR: clear_busy=1; wr_ready=0 (paint writes held off, not dropped). Reads keep priority;
//    in any cycle without a read grant, write CLEAR_COLOR to clear_addr, clear_addr++.
//    After writing address VRAM_L-1: clear_addr<=0, -> S_IDLE, clear_done pulses next cycle
//    (clear_busy low same cycle as clear_done). Starvation guard does not apply to the sweep.
//  - clear_start while in S_CLEAR: ignored (no restart).
//  - Write with wr_addr >= VRAM_L: accepted (wr_ready=1 per normal arbitration), ram_wr_ena=0.
//    Read with rd_addr >= VRAM_L: granted, returns rd_data=16'h0000.
//  - Same-address read and write in one cycle: read granted, write stalled; read returns old data.
//  - Reset mid-clear: sweep aborted, no clear_done; VRAM contents undefined-partial (not restored).
//  - ram_addr/ram_wr_data are comb. mux of granted source; ram_wr_ena only on write/clear grant.
// STRUCTURE
//  - ILI9341_color_t and color constants (BLACK, WHITE) stay in ili9341_defines.sv; VRAM
//    geometry/address-width localparams shared via a new vram_defines.sv include.
//  - Arbiter state enum local to the module.
//  - One natural sub-module: vram_clear_sweeper (address counter, last-address detect, done pulse);
//    arbiter top owns grant mux and starvation counter.
// TESTING
//  1. Reset: hold rstb=0 2 cycles, drive all reqs -> all outputs at reset values, no ram_wr_ena.
//  2. Read only: rd_req, rd_addr=100, RAM preloaded 16'hF800 -> rd_ready=1, rd_valid=1 next cycle,
//     rd_data=16'hF800.
//  3. Contention: rd_req held high continuously, wr_req addr=5 data=16'hFFFF -> write granted on
//     cycle MAX_WR_WAIT+1 (9th), rd_ready=0 that cycle; RAM[5]==16'hFFFF after.
//  4. Clear: clear_start with no reads -> clear_busy for exactly 76800 cycles, clear_done pulse
//     once, all RAM words==16'h0000; wr_req during sweep not accepted until clear_done.
//  5. Clear with interleaved reads every other cycle -> sweep takes 2x cycles, every read returns
//     correct data, clear_start mid-sweep ignored, single clear_done.
//  6. rstb=0 at clear_addr=1000 -> clear_busy=0 next cycle, no clear_done; wr_addr=76800 -> accepted,
//     no RAM write.

Source files
------------

// File: rtl/vram_port_arbiter_pkg.sv
// Shared types and constants for the VRAM port arbiter.
//  - ili9341_color_t : 16-bit RGB565 pixel word stored in VRAM
//  - BLACK / WHITE   : common color constants
//  - DEF_*           : default display geometry and write starvation limit
//  - vram_aw()       : address width for a given VRAM depth
package vram_port_arbiter_pkg;

   typedef logic [15:0] ili9341_color_t;

   localparam ili9341_color_t BLACK = 16'h0000;
   localparam ili9341_color_t WHITE = 16'hFFFF;

   localparam int DEF_DISPLAY_WIDTH  = 240;
   localparam int DEF_DISPLAY_HEIGHT = 320;
   localparam int DEF_VRAM_L         = DEF_DISPLAY_WIDTH * DEF_DISPLAY_HEIGHT;
   localparam int DEF_MAX_WR_WAIT    = 8;

   function automatic int vram_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/vram_port_arbiter_clear_sweeper.sv
// Clear-screen address sequencer.
//  clk   in   system clock
//  rstb  in   synchronous reset, active low (aborts a sweep without a done pulse)
//  step  in   a clear write to addr is issued this cycle
//  addr  out  next VRAM address to clear
//  last  out  addr is the final VRAM word
//  done  out  one-cycle pulse the cycle after the final word is written
module vram_clear_sweeper
   import vram_port_arbiter_pkg::*;
#(
   parameter int VRAM_L = DEF_VRAM_L,
   parameter int AW     = vram_aw(VRAM_L)
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          step,
   output logic [AW-1:0] addr,
   output logic          last,
   output logic          done
);

   assign last = (addr == AW'(VRAM_L - 1));

   always_ff @(posedge clk) begin
      if (!rstb) begin
         addr <= '0;
         done <= 1'b0;
      end else begin
         done <= step & last;
         if (step) begin
            // wrap so the next sweep starts from the top of the frame
            addr <= last ? '0 : addr + AW'(1);
         end
      end
   end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display reads, paint writes and a clear-screen sweep
// share one block RAM access per clock.
//  clk, rstb            clock, synchronous active-low reset
//  rd_req/rd_addr       display read request; rd_ready = granted this cycle
//  rd_valid/rd_data     read data, one cycle after grant
//  wr_req/addr/data     paint write request; wr_ready = accepted this cycle
//  clear_start          pulse to start a full-frame clear
//  clear_busy/done      sweep in progress / one-cycle completion pulse
//  ram_*                block RAM port (1-cycle read latency)
module vram_port_arbiter
   import vram_port_arbiter_pkg::*;
#(
   parameter int             DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
   parameter int             DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
   parameter int             VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
   parameter int             AW             = vram_aw(VRAM_L),
   parameter ili9341_color_t CLEAR_COLOR    = BLACK,
   parameter int             MAX_WR_WAIT    = DEF_MAX_WR_WAIT
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_ready,
   output logic          rd_valid,
   output logic [15:0]   rd_data,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   output logic          wr_ready,
   input  logic          clear_start,
   output logic          clear_busy,
   output logic          clear_done,
   output logic [AW-1:0] ram_addr,
   output logic          ram_wr_ena,
   output logic [15:0]   ram_wr_data,
   input  logic [15:0]   ram_rd_data
);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   localparam int           WCW   = (MAX_WR_WAIT > 0) ? $clog2(MAX_WR_WAIT + 1) : 1;
   localparam logic [WCW-1:0] WMAX = WCW'(MAX_WR_WAIT);
   localparam logic [AW:0]  DEPTH = (AW + 1)'(VRAM_L);

   state_t          state, state_next;
   logic [WCW-1:0]  wait_cnt;
   logic            wr_starved;
   logic            rd_in_range, wr_in_range;
   logic            clear_step, clear_last;
   logic [AW-1:0]   clear_addr;
   logic            rd_oob_p1;

   assign wr_starved  = (wait_cnt == WMAX);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH);
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
   assign clear_busy  = (state == S_CLEAR);

   vram_clear_sweeper #(
      .VRAM_L (VRAM_L),
      .AW     (AW)
   ) u_sweeper (
      .clk  (clk),
      .rstb (rstb),
      .step (clear_step),
      .addr (clear_addr),
      .last (clear_last),
      .done (clear_done)
   );

   always_comb begin
      rd_ready    = 1'b0;
      wr_ready    = 1'b0;
      ram_addr    = '0;
      ram_wr_ena  = 1'b0;
      ram_wr_data = BLACK;
      clear_step  = 1'b0;
      state_next  = state;
      // no grants while reset is asserted, whatever the requesters drive
      if (rstb) begin
         case (state)
            S_IDLE: begin
               if (rd_req && !wr_starved) begin
                  rd_ready = 1'b1;
                  ram_addr = rd_addr;
               end else if (wr_req) begin
                  // out-of-range writes are consumed but never reach the RAM
                  wr_ready    = 1'b1;
                  ram_addr    = wr_addr;
                  ram_wr_data = wr_data;
                  ram_wr_ena  = wr_in_range;
               end
               if (clear_start) begin
                  state_next = S_CLEAR;
               end
            end
            S_CLEAR: begin
               // reads keep priority; the sweep fills every idle slot
               if (rd_req) begin
                  rd_ready = 1'b1;
                  ram_addr = rd_addr;
               end else begin
                  clear_step  = 1'b1;
                  ram_addr    = clear_addr;
                  ram_wr_data = CLEAR_COLOR;
                  ram_wr_ena  = 1'b1;
                  if (clear_last) begin
                     state_next = S_IDLE;
                  end
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         rd_valid <= 1'b0;
      end else begin
         state    <= state_next;
         rd_valid <= rd_ready;
         if (wr_req && !wr_ready) begin
            if (!wr_starved) begin
               wait_cnt <= wait_cnt + WCW'(1);
            end
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   // ---- stage p1: RAM read data returns ----
   always_ff @(posedge clk) begin
      rd_oob_p1 <= rd_ready & ~rd_in_range;
   end

   assign rd_data = rd_oob_p1 ? 16'h0000 : ram_rd_data;

endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;

   localparam int W  = 12;
   localparam int H  = 10;
   localparam int V  = W * H;   // 120 words, addresses 120..127 are out of range
   localparam int AW = 7;

   logic          clk;
   logic          rstb;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ready;
   logic          rd_valid;
   logic [15:0]   rd_data;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          wr_ready;
   logic          clear_start;
   logic          clear_busy;
   logic          clear_done;
   logic [AW-1:0] ram_addr;
   logic          ram_wr_ena;
   logic [15:0]   ram_wr_data;
   logic [15:0]   ram_rd_data;

   vram_port_arbiter #(
      .DISPLAY_WIDTH  (W),
      .DISPLAY_HEIGHT (H)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_ready    (rd_ready),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .ram_addr    (ram_addr),
      .ram_wr_ena  (ram_wr_ena),
      .ram_wr_data (ram_wr_data),
      .ram_rd_data (ram_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // block RAM model with a bench-side preload port
   logic [15:0]   mem [0:(1<<AW)-1];
   logic          bk_we;
   logic [AW-1:0] bk_addr;
   logic [15:0]   bk_data;

   always @(posedge clk) begin
      if (bk_we) mem[bk_addr] <= bk_data;
      if (ram_wr_ena) mem[ram_addr] <= ram_wr_data;
      ram_rd_data <= mem[ram_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // call just after a negedge; returns just after the following negedge
   task automatic bk_write(input logic [AW-1:0] a, input logic [15:0] d);
      bk_we = 1'b1;
      bk_addr = a;
      bk_data = d;
      @(negedge clk);
      bk_we = 1'b0;
   endtask

   typedef struct {
      logic          rd_req;
      logic [AW-1:0] rd_addr;
      logic          wr_req;
      logic [AW-1:0] wr_addr;
      logic [15:0]   wr_data;
      logic          e_rd_ready;
      logic          e_wr_ready;
      logic          e_wr_ena;
      logic [AW-1:0] e_ram_addr;
      logic          e_rd_valid;
      logic [15:0]   e_rd_data;
   } vec_t;

   localparam int NV = 10;
   vec_t vec [NV];

   logic [15:0] model [0:(1<<AW)-1];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int busy_cnt, done_cnt, wr_leak, rd_bad, bad, cyc, ptr;
      logic got_done, pend;
      logic [15:0] pend_exp;

      //             rd  rd_addr wr  wr_addr wr_data    rr wr en addr  vld data
      vec[0] = '{1'b1, 7'd100, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 7'd100, 1'b1, 16'hF800};
      vec[1] = '{1'b0, 7'd0,   1'b1, 7'd5,   16'h1234, 1'b0, 1'b1, 1'b1, 7'd5,   1'b0, 16'h0000};
      vec[2] = '{1'b1, 7'd5,   1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 7'd5,   1'b1, 16'h1234};
      vec[3] = '{1'b1, 7'd7,   1'b1, 7'd7,   16'hABCD, 1'b1, 1'b0, 1'b0, 7'd7,   1'b1, 16'h0707};
      vec[4] = '{1'b0, 7'd0,   1'b1, 7'd7,   16'hABCD, 1'b0, 1'b1, 1'b1, 7'd7,   1'b0, 16'h0000};
      vec[5] = '{1'b1, 7'd7,   1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 7'd7,   1'b1, 16'hABCD};
      vec[6] = '{1'b0, 7'd0,   1'b1, 7'd125, 16'h5555, 1'b0, 1'b1, 1'b0, 7'd125, 1'b0, 16'h0000};
      vec[7] = '{1'b1, 7'd125, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 7'd125, 1'b1, 16'h0000};
      vec[8] = '{1'b1, 7'd119, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 7'd119, 1'b1, 16'h0119};
      vec[9] = '{1'b0, 7'd0,   1'b0, 7'd0,   16'h0000, 1'b0, 1'b0, 1'b0, 7'd0,   1'b0, 16'h0000};

      bk_we = 1'b0; bk_addr = '0; bk_data = '0;

      // reset with every request asserted
      rstb = 1'b0;
      rd_req = 1'b1; rd_addr = 7'd9;
      wr_req = 1'b1; wr_addr = 7'd9; wr_data = 16'h4321;
      clear_start = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_rd_ready", rd_ready, 0);
      check("reset_wr_ready", wr_ready, 0);
      check("reset_ram_wr_ena", ram_wr_ena, 0);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_clear_busy", clear_busy, 0);
      check("reset_clear_done", clear_done, 0);
      @(negedge clk);
      rstb = 1'b1;
      rd_req = 1'b0; wr_req = 1'b0; clear_start = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      #1;
      check("idle_rd_ready", rd_ready, 0);
      check("idle_wr_ready", wr_ready, 0);
      check("idle_ram_addr", ram_addr, 0);
      check("idle_ram_wr_ena", ram_wr_ena, 0);
      @(negedge clk);

      bk_write(7'd100, 16'hF800);
      bk_write(7'd7,   16'h0707);
      bk_write(7'd125, 16'hDEAD);
      bk_write(7'd119, 16'h0119);

      // table of single-cycle arbitration vectors
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rd_req = vec[i].rd_req; rd_addr = vec[i].rd_addr;
         wr_req = vec[i].wr_req; wr_addr = vec[i].wr_addr; wr_data = vec[i].wr_data;
         #1;
         check($sformatf("vec%0d_rd_ready", i), rd_ready, vec[i].e_rd_ready);
         check($sformatf("vec%0d_wr_ready", i), wr_ready, vec[i].e_wr_ready);
         check($sformatf("vec%0d_ram_wr_ena", i), ram_wr_ena, vec[i].e_wr_ena);
         check($sformatf("vec%0d_ram_addr", i), ram_addr, vec[i].e_ram_addr);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_rd_valid", i), rd_valid, vec[i].e_rd_valid);
         if (vec[i].e_rd_valid)
            check($sformatf("vec%0d_rd_data", i), rd_data, vec[i].e_rd_data);
      end

      // starvation guard: write wins on its 9th blocked cycle
      @(negedge clk);
      rd_req = 1'b1; rd_addr = 7'd100;
      wr_req = 1'b1; wr_addr = 7'd5; wr_data = 16'hFFFF;
      for (int c = 1; c <= 9; c++) begin
         #1;
         check($sformatf("contend_c%0d_rd_ready", c), rd_ready, (c < 9));
         check($sformatf("contend_c%0d_wr_ready", c), wr_ready, (c == 9));
         if (c == 9) begin
            check("contend_ram_wr_ena", ram_wr_ena, 1);
            check("contend_ram_addr", ram_addr, 5);
         end
         @(negedge clk);
      end
      rd_req = 1'b0; wr_req = 1'b0;
      @(negedge clk);
      check("contend_mem5", mem[5], 16'hFFFF);

      // full clear without reads, paint write held off until done
      clear_start = 1'b1;
      #1;
      check("clear_busy_before_start", clear_busy, 0);
      @(negedge clk);
      clear_start = 1'b0;
      wr_req = 1'b1; wr_addr = 7'd3; wr_data = 16'h7777;
      busy_cnt = 0; done_cnt = 0; wr_leak = 0; got_done = 1'b0;
      for (int n = 0; n < 2 * V + 20 && !got_done; n++) begin
         #1;
         if (clear_done) begin
            got_done = 1'b1;
            done_cnt++;
            check("clear_wr_ready_at_done", wr_ready, 1);
            check("clear_busy_at_done", clear_busy, 0);
         end else begin
            if (clear_busy) busy_cnt++;
            if (wr_ready) wr_leak++;
         end
         @(negedge clk);
      end
      wr_req = 1'b0;
      check("clear_done_seen", got_done, 1);
      for (int n = 0; n < 3; n++) begin
         #1;
         if (clear_done) done_cnt++;
         @(negedge clk);
      end
      check("clear_busy_cycles", busy_cnt, V);
      check("clear_done_pulses", done_cnt, 1);
      check("clear_wr_leak", wr_leak, 0);
      bad = 0;
      for (int i = 0; i < V; i++) begin
         if (mem[i] !== ((i == 3) ? 16'h7777 : 16'h0000)) bad++;
      end
      check("clear_mem_bad_words", bad, 0);

      // clear with a read every other cycle and a restart attempt mid-sweep
      for (int i = 0; i < V; i++) begin
         bk_write(AW'(i), 16'h1000 + 16'(i));
         model[i] = 16'h1000 + 16'(i);
      end
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      busy_cnt = 0; done_cnt = 0; rd_bad = 0; got_done = 1'b0;
      cyc = 0; ptr = 0; pend = 1'b0; pend_exp = '0;
      while (!got_done && cyc < 4 * V) begin
         rd_req = (cyc % 2 == 0);
         rd_addr = AW'((cyc * 7) % V);
         clear_start = (cyc == V);
         #1;
         if (pend) begin
            if (rd_valid !== 1'b1 || rd_data !== pend_exp) rd_bad++;
            pend = 1'b0;
         end
         if (clear_done) begin
            got_done = 1'b1;
            done_cnt++;
         end else begin
            if (clear_busy) busy_cnt++;
            if (rd_req) begin
               if (rd_ready !== 1'b1) rd_bad++;
               pend = 1'b1;
               pend_exp = model[rd_addr];
            end else begin
               if (ptr < V) model[ptr] = 16'h0000;
               ptr++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      rd_req = 1'b0; clear_start = 1'b0;
      check("sweep_done_seen", got_done, 1);
      for (int n = 0; n < 3; n++) begin
         #1;
         if (clear_done) done_cnt++;
         @(negedge clk);
      end
      check("sweep_busy_cycles", busy_cnt, 2 * V);
      check("sweep_done_pulses", done_cnt, 1);
      check("sweep_read_errors", rd_bad, 0);
      bad = 0;
      for (int i = 0; i < V; i++) begin
         if (mem[i] !== 16'h0000) bad++;
      end
      check("sweep_mem_bad_words", bad, 0);

      // reset in the middle of a sweep
      bk_write(7'd120, 16'hBEEF);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      repeat (50) @(negedge clk);
      #1;
      check("abort_busy_before_reset", clear_busy, 1);
      rstb = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy_after_reset", clear_busy, 0);
      check("abort_done_after_reset", clear_done, 0);
      @(negedge clk);
      rstb = 1'b1;
      done_cnt = 0;
      for (int n = 0; n < 4; n++) begin
         #1;
         if (clear_done) done_cnt++;
         @(negedge clk);
      end
      check("abort_no_done", done_cnt, 0);

      // write just past the end of VRAM
      wr_req = 1'b1; wr_addr = 7'd120; wr_data = 16'h1111;
      #1;
      check("oob_wr_ready", wr_ready, 1);
      check("oob_wr_ena", ram_wr_ena, 0);
      @(negedge clk);
      wr_req = 1'b0;
      @(negedge clk);
      check("oob_mem_untouched", mem[120], 16'hBEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
